decode_stage: RTL and testbench

Instruction decode pipeline stage sitting between instruction fetch and the immediate extender / register file / ALU. It accepts one 32-bit ARM-style instruction per cycle over a valid/ready handshake and registers the decoded control fields. It presents the raw 24-bit immediate field and the 2-bit immediate-source select that the immediate extender consumes. A two-entry skid buffer keeps `in_ready` a registered signal, so backpressure does not ripple combinationally into fetch.

---
 rtl/decode_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes one ARM-style word per cycle into a registered
// control bundle, with a two-entry (main + skid) buffer so in_ready is registered.
module decode_stage #(
  parameter int unsigned LINK_REG = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [23:0] immediate,
  output logic [1:0]  imm_src,
  output logic [3:0]  cond,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        set_flags,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        link,
  output logic        illegal
);

  localparam int unsigned RegW = 4;

  localparam logic [1:0] ImmDp     = 2'b00;
  localparam logic [1:0] ImmMem    = 2'b01;
  localparam logic [1:0] ImmBranch = 2'b10;
  localparam logic [1:0] ImmNone   = 2'b11;

  localparam logic [3:0] AluAdd = 4'b0100;
  localparam logic [3:0] AluSub = 4'b0010;

  typedef struct packed {
    logic [31:0]     pc;
    logic [23:0]     immediate;
    logic [1:0]      imm_src;
    logic [3:0]      cond;
    logic [RegW-1:0] rn;
    logic [RegW-1:0] rd;
    logic [RegW-1:0] rm;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            set_flags;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            link;
    logic            illegal;
  } bundle_t;

  bundle_t dec_c;
  bundle_t main_q;
  bundle_t skid_q;
  logic    main_valid_q;
  logic    skid_valid_q;
  logic    in_ready_q;
  logic    accept_c;
  logic    drain_c;

  // Combinational decode of the incoming word
  always_comb begin
    dec_c           = '0;
    dec_c.pc        = pc;
    dec_c.immediate = instr[23:0];
    dec_c.cond      = instr[31:28];
    dec_c.rn        = instr[19:16];
    dec_c.rd        = instr[15:12];
    dec_c.rm        = instr[3:0];
    dec_c.imm_src   = ImmNone;
    case (instr[27:26])
      2'b00: begin
        dec_c.alu_op      = instr[24:21];
        dec_c.set_flags   = instr[20];
        dec_c.alu_src_imm = instr[25];
        dec_c.imm_src     = instr[25] ? ImmDp : ImmNone;
        // TST/TEQ/CMP/CMN only update flags
        dec_c.reg_write   = (instr[24:23] != 2'b10);
      end
      2'b01: begin
        dec_c.alu_src_imm = ~instr[25];
        dec_c.imm_src     = instr[25] ? ImmNone : ImmMem;
        dec_c.alu_op      = instr[23] ? AluAdd : AluSub;
        dec_c.reg_write   = instr[20];
        dec_c.mem_to_reg  = instr[20];
        dec_c.mem_write   = ~instr[20];
      end
      2'b10: begin
        dec_c.imm_src = ImmBranch;
        dec_c.branch  = 1'b1;
        dec_c.link    = instr[24];
        if (instr[24]) begin
          dec_c.reg_write = 1'b1;
          dec_c.rd        = RegW'(LINK_REG);
        end
      end
      default: begin
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  assign accept_c = in_valid & in_ready_q;
  assign drain_c  = main_valid_q & out_ready;

  // Main/skid buffer; skid only fills while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (!main_valid_q || (drain_c && !skid_valid_q)) begin
      if (accept_c) begin
        main_q       <= dec_c;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (drain_c) begin
      main_q       <= skid_q;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (accept_c) begin
      skid_q       <= dec_c;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign pc_out      = main_q.pc;
  assign immediate   = main_q.immediate;
  assign imm_src     = main_q.imm_src;
  assign cond        = main_q.cond;
  assign rn          = main_q.rn;
  assign rd          = main_q.rd;
  assign rm          = main_q.rm;
  assign alu_op      = main_q.alu_op;
  assign alu_src_imm = main_q.alu_src_imm;
  assign set_flags   = main_q.set_flags;
  assign reg_write   = main_q.reg_write;
  assign mem_write   = main_q.mem_write;
  assign mem_to_reg  = main_q.mem_to_reg;
  assign branch      = main_q.branch;
  assign link        = main_q.link;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: reference decoder predicts each accepted
// bundle, which must reappear in order at the output handshake.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [23:0] immediate;
    logic [1:0]  imm_src;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        set_flags;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        link;
    logic        illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [23:0] immediate;
  logic [1:0]  imm_src;
  logic [3:0]  cond, rn, rd, rm, alu_op;
  logic        alu_src_imm, set_flags, reg_write, mem_write, mem_to_reg;
  logic        branch, link, illegal;

  int checks = 0;
  int failures = 0;
  bundle_t sb[$];
  bundle_t got;

  always #5 clk = ~clk;

  decode_stage #(.LINK_REG(14)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .immediate(immediate), .imm_src(imm_src), .cond(cond),
    .rn(rn), .rd(rd), .rm(rm), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .set_flags(set_flags), .reg_write(reg_write),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
    .link(link), .illegal(illegal)
  );

  assign got = '{pc_out, immediate, imm_src, cond, rn, rd, rm, alu_op,
                 alu_src_imm, set_flags, reg_write, mem_write, mem_to_reg,
                 branch, link, illegal};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t model(input logic [31:0] i, input logic [31:0] a);
    bundle_t b;
    b = '0;
    b.pc = a;
    b.immediate = i[23:0];
    b.cond = i[31:28];
    b.rn = i[19:16];
    b.rd = i[15:12];
    b.rm = i[3:0];
    case (i[27:26])
      2'd0: begin
        b.alu_op = i[24:21];
        b.set_flags = i[20];
        b.alu_src_imm = i[25];
        b.imm_src = i[25] ? 2'd0 : 2'd3;
        b.reg_write = !(i[24:21] inside {4'd8, 4'd9, 4'd10, 4'd11});
      end
      2'd1: begin
        b.alu_src_imm = !i[25];
        b.imm_src = i[25] ? 2'd3 : 2'd1;
        b.alu_op = i[23] ? 4'd4 : 4'd2;
        if (i[20]) begin
          b.reg_write = 1'b1;
          b.mem_to_reg = 1'b1;
        end else begin
          b.mem_write = 1'b1;
        end
      end
      2'd2: begin
        b.imm_src = 2'd2;
        b.branch = 1'b1;
        b.link = i[24];
        if (i[24]) begin
          b.reg_write = 1'b1;
          b.rd = 4'd14;
        end
      end
      default: begin
        b.illegal = 1'b1;
        b.imm_src = 2'd3;
      end
    endcase
    return b;
  endfunction

  // Scoreboard: compare on drain, predict on accept, forget on flush
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_bundle", 128'(got), 128'(0));
        else check("bundle", 128'(got), 128'(sb.pop_front()));
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(instr, pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded)
  task automatic send(input logic [31:0] i, input logic [31:0] a);
    int n;
    in_valid = 1'b1;
    instr = i;
    pc = a;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("send_timeout", 128'(1), 128'(0));
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    pc = '0;
    out_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    step();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Directed decodes, one cycle after accept
    send(32'hE3A01005, 32'h100);
    check("mov_valid", 128'(out_valid), 128'(1));
    check("mov_imm_src", 128'(imm_src), 128'(2'b00));
    check("mov_immediate", 128'(immediate), 128'(24'hA01005));
    check("mov_alu_op", 128'(alu_op), 128'(4'b1101));
    check("mov_rd", 128'(rd), 128'(1));
    check("mov_rw_src", 128'({reg_write, alu_src_imm}), 128'(2'b11));
    send(32'hE3500000, 32'h104);
    check("cmp_flags", 128'({reg_write, set_flags}), 128'(2'b01));
    check("cmp_alu_op", 128'(alu_op), 128'(4'b1010));
    send(32'hE5932004, 32'h108);
    check("ldr_imm", 128'({imm_src, immediate}), 128'({2'b01, 24'h932004}));
    check("ldr_regs", 128'({rn, rd, alu_op}), 128'({4'd3, 4'd2, 4'b0100}));
    check("ldr_ctl", 128'({mem_to_reg, reg_write, mem_write}), 128'(3'b110));
    send(32'hEB000010, 32'h10C);
    check("bl_imm", 128'({imm_src, immediate}), 128'({2'b10, 24'h000010}));
    check("bl_ctl", 128'({branch, link, reg_write, rd}), 128'({3'b111, 4'd14}));
    send(32'hEC000000, 32'h110);
    check("ill", 128'({illegal, imm_src}), 128'({1'b1, 2'b11}));
    step();
    check("idle_valid", 128'(out_valid), 128'(0));

    // Backpressure: 0x0 in main, 0x4 in skid, 0x8 stalls
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'hE0812003; pc = 32'h0; step();
    instr = 32'hE5832000; pc = 32'h4; step();
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_pc_main", 128'(pc_out), 128'(32'h0));
    instr = 32'hEA000003; pc = 32'h8; step();
    check("bp_stall_ready", 128'(in_ready), 128'(0));
    check("bp_hold_pc", 128'(pc_out), 128'(32'h0));
    check("bp_hold_imm", 128'(immediate), 128'(24'h812003));
    out_ready = 1'b1;
    step();
    check("bp_pc_1", 128'(pc_out), 128'(32'h4));
    check("bp_ready_back", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    check("bp_pc_2", 128'(pc_out), 128'(32'h8));
    step();
    check("bp_empty", 128'(out_valid), 128'(0));

    // Flush with main full, plus a simultaneous accept
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'hE2811001; pc = 32'h200; step();
    instr = 32'hE2822002; pc = 32'h204; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", 128'(out_valid), 128'(0));
    check("flush1_ready", 128'(in_ready), 128'(1));

    // Flush with both entries full and a word offered
    in_valid = 1'b1;
    instr = 32'hE2833003; pc = 32'h300; step();
    instr = 32'hE2844004; pc = 32'h304; step();
    instr = 32'hE2855005; pc = 32'h308; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_valid", 128'(out_valid), 128'(0));
    check("flush2_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    send(32'hE1A06007, 32'h400);
    check("post_flush_pc", 128'(pc_out), 128'(32'h400));

    // Random traffic through the scoreboard
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      instr = $urandom();
      pc = 32'h1000 + 32'(k * 4);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    check("sb_drained", 128'(sb.size()), 128'(0));

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'hE3A0F0FF; pc = 32'h500; step();
    instr = 32'hE59F1008; pc = 32'h504; step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    check("arst_imm", 128'({imm_src, immediate}), 128'(0));
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'hE3A01005, 32'h600);
    check("post_rst_pc", 128'(pc_out), 128'(32'h600));
    step();
    check("final_sb", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
